alu_req_responder: RTL
======================

// Module: alu_req_responder
// PURPOSE
//  Responder side of the ALU operation interface. It accepts {a, b, op, tag} requests over a
//  valid/ready handshake and computes the ALU result through alu_core.
//  Results return on a buffered valid/ready response channel, with zero, overflow and
//  illegal-op flags. A stimulus/checker bench or a multicycle datapath controller sits upstream.
// PARAMETERS
//  W      32  operand/result width
//  TAG_W  4   request tag width, echoed unchanged on the response
//  CNT_W  16  width of the statistics counters
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset (sampled on clk rising edge)
//  req_valid  in   1      request present
//  req_ready  out  1      responder can accept this cycle
//  req_a      in   W      operand a
//  req_b      in   W      operand b
//  req_op     in   3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
//  req_tag    in   TAG_W  requester tag
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_z      out  W      result
//  rsp_zero   out  1      rsp_z == 0
//  rsp_ex     out  1      signed overflow (ADD/SUB only; 0 for other ops)
//  rsp_err    out  1      illegal op
//  rsp_tag    out  TAG_W  tag of the request
//  stat_ops   out  CNT_W  accepted requests; wraps modulo 2^CNT_W
//  stat_err   out  CNT_W  accepted illegal-op requests; saturates at all-ones
// BEHAVIOUR
//  - Handshakes: a request transfers when req_valid && req_ready; a response transfers when rsp_valid && rsp_ready.
//  - Once rsp_valid is high, the payload is held stable until the transfer; rsp_valid is never withdrawn.
//  - Results are computed combinationally from the request and written into a 2-entry response FIFO on accept.
//  - Latency: a request accepted in cycle N produces rsp_valid high in cycle N+1 when the FIFO was empty.
//  - FIFO has no combinational bypass.
//  - req_ready = (count != 2); it is a registered function of count only, with no path from rsp_ready.
//  - Throughput is 1 per cycle while rsp_ready stays high.
//  - Count states: EMPTY(0), ONE(1), FULL(2).
//  - Push only -> count+1. Pop only -> count-1. Push and pop in the same cycle -> count unchanged, order preserved.
//  - At FULL, push is impossible because req_ready is low.
//  - Read/write pointers are 1 bit and wrap 1->0.
//  - Arithmetic is W bits, with carry-out discarded:
//      ADD: z = a + b; ex = sign(a)==sign(b) && sign(z)!=sign(a).
//      SUB: z = a - b; ex = sign(a)!=sign(b) && sign(z)!=sign(a).
//      SLT: signed compare; z = {W-1 zeros, (a <s b)}.
//  - Illegal op: z = 0, zero = 1, ex = 0, err = 1. The response is still produced and stat_err increments.
//  - stat_ops increments on every accepted request, legal or not.
//  - Reset (rst_n low at a clock edge, including mid-stream):
//      FIFO flushed, count = 0, rsp_valid = 0, req_ready = 1.
//      rsp_z/rsp_zero/rsp_ex/rsp_err/rsp_tag = 0.
//      stat_ops = stat_err = 0.
//      In-flight requests are dropped.
//      While rst_n is low, req_ready stays 1 but nothing is captured.
// STRUCTURE
//  - Package alu_pkg holds:
//      op code constants OP_AND/OP_OR/OP_ADD/OP_SUB/OP_SLT;
//      a response record type {z, zero, ex, err, tag};
//      a function is_legal_op().
//  - Sub-module alu_core (combinational) maps (a, b, op) to (z, zero, ex, err).
//  - The top level holds the 2-entry FIFO, the handshakes and the counters.
// TESTING
//  1. Reset with rsp_ready=1. Request a=5, b=3, op=010, tag=1.
//     -> Next cycle: rsp_valid=1, z=8, zero=0, ex=0, tag=1; stat_ops=1.
//  2. SUB a=b=32'h1234_5678 -> z=0, zero=1.
//     SLT a=32'hFFFF_FFFF (-1), b=1 -> z=1.
//     SLT a=1, b=32'hFFFF_FFFF -> z=0.
//  3. ADD a=32'h7FFF_FFFF, b=1 -> z=32'h8000_0000, ex=1.
//     SUB a=32'h8000_0000, b=1 -> z=32'h7FFF_FFFF, ex=1.
//     AND/OR -> ex=0.
//  4. Backpressure: rsp_ready=0, issue tags 1, 2, 3.
//     -> Tags 1 and 2 accepted; req_ready=0 while tag 3 waits; payload stable.
//     Release rsp_ready -> responses appear in order 1, 2, 3.
//  5. Illegal op=011 with a=9, b=9 -> z=0, zero=1, err=1; stat_err=1, stat_ops increments.
//  6. FIFO FULL, then rst_n=0 for 1 cycle
//     -> rsp_valid=0, counters=0, req_ready=1; the next request responds normally with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request/response slice: op codes, FIFO occupancy
// states, the response record and the op legality check.
package alu_pkg;

  localparam int unsigned ALU_W     = 32;
  localparam int unsigned ALU_TAG_W = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_e;

  typedef struct packed {
    logic [ALU_W-1:0]     z;
    logic                 zero;
    logic                 ex;
    logic                 err;
    logic [ALU_TAG_W-1:0] tag;
  } rsp_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: maps (a, b, op) to result, zero, signed-overflow and illegal-op flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] z,
  output logic         zero,
  output logic         ex,
  output logic         err
);

  always_comb begin
    z   = '0;
    ex  = 1'b0;
    err = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: begin
        z  = a + b;
        ex = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]);
      end
      OP_SUB: begin
        z  = a - b;
        ex = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]);
      end
      OP_SLT: z = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: err = 1'b1;
    endcase
    zero = (z == '0);
  end

endmodule

// File: rtl/alu_req_responder.sv
// ALU responder: accepts requests, computes through alu_core, and returns results via a
// 2-entry response FIFO with registered handshake outputs and statistics counters.
module alu_req_responder
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned TAG_W = ALU_TAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_z,
  output logic             rsp_zero,
  output logic             rsp_ex,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_err
);

  rsp_t       mem [2];
  rsp_t       rsp_in;
  rsp_t       head;
  logic       wr_ptr, rd_ptr;
  logic       push, pop;
  cnt_e       state, state_nx;
  logic [W-1:0] core_z;
  logic       core_zero, core_ex, core_err;

  alu_core #(.W(W)) u_core (
    .a    (req_a),
    .b    (req_b),
    .op   (req_op),
    .z    (core_z),
    .zero (core_zero),
    .ex   (core_ex),
    .err  (core_err)
  );

  always_comb begin
    rsp_in      = '0;
    rsp_in.z    = core_z;
    rsp_in.zero = core_zero;
    rsp_in.ex   = core_ex;
    rsp_in.err  = core_err;
    rsp_in.tag  = req_tag;
  end

  assign push = req_valid && req_ready;
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (push) state_nx = ONE;
      ONE:     if (push && !pop) state_nx = FULL;
               else if (pop && !push) state_nx = EMPTY;
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // req_ready and rsp_valid are registered from the next occupancy, so neither
  // has a combinational path from rsp_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      stat_ops    <= '0;
      stat_err    <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= (state_nx != FULL);
      rsp_valid <= (state_nx != EMPTY);
      if (push) begin
        mem[wr_ptr] <= rsp_in;
        wr_ptr      <= ~wr_ptr;
        stat_ops    <= stat_ops + CNT_W'(1);
        if (rsp_in.err && (stat_err != '1))
          stat_err <= stat_err + CNT_W'(1);
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

  assign head     = mem[rd_ptr];
  assign rsp_z    = head.z;
  assign rsp_zero = head.zero;
  assign rsp_ex   = head.ex;
  assign rsp_err  = head.err;
  assign rsp_tag  = head.tag;

endmodule
